// File: rtl/knn_select.sv
// knn_select: keeps the K smallest (distance, label) pairs of a query in a
// sorted register list and streams them out in ascending order on flush.
//
// state   | meaning
// COLLECT | accepting pairs, sorted insertion, waiting for flush
// DRAIN   | presenting retained slots to the vote logic, slot 0 first

module knn_select #(
    parameter int VARWIDTH   = 32,
    parameter int LABELWIDTH = 8,
    parameter int K          = 4,
    parameter int FLOAT      = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_rdy,
    input  logic [VARWIDTH-1:0]      in_dist,
    input  logic [LABELWIDTH-1:0]    in_label,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_rdy,
    output logic [VARWIDTH-1:0]      out_dist,
    output logic [LABELWIDTH-1:0]    out_label,
    output logic                     out_last,
    output logic [$clog2(K+1)-1:0]   count,
    output logic                     done
);

    localparam int CW = $clog2(K+1);

    typedef enum logic {COLLECT, DRAIN} state_t;

    state_t                  state_q, state_d;
    logic [K-1:0]            occ_q;
    logic [VARWIDTH-1:0]     dist_q  [K];
    logic [LABELWIDTH-1:0]   label_q [K];
    logic [CW-1:0]           count_q;
    logic [CW-1:0]           rd_ptr_q;
    logic                    done_q;

    logic [K-1:0]            le;
    logic [K:0]              le_ext;
    logic [K-1:0]            prev_occ;
    logic [VARWIDTH-1:0]     prev_dist  [K];
    logic [LABELWIDTH-1:0]   prev_label [K];
    logic [VARWIDTH-1:0]     in_key;
    logic                    do_insert;
    logic [CW-1:0]           post_count;
    logic                    xfer;
    logic                    last_xfer;
    logic                    done_set;

    // Floats are non-negative, so dropping the sign bit makes -0.0 equal +0.0
    // and lets the raw bit pattern be compared as an unsigned integer. The
    // stored value is this key, so -0.0 comes back out as 0.
    function automatic logic [VARWIDTH-1:0] to_key(input logic [VARWIDTH-1:0] d);
        if (FLOAT != 0) return {1'b0, d[VARWIDTH-2:0]};
        else            return d;
    endfunction

    assign in_key = to_key(in_dist);

    // Parallel compare: le is a thermometer code, ones for slots that stay ahead
    always_comb begin
        le = '0;
        for (int i = 0; i < K; i++)
            le[i] = occ_q[i] && (dist_q[i] <= in_key);
    end

    // le_ext[i] is "slot i-1 stays ahead", with a virtual always-ahead slot -1
    assign le_ext = {le, 1'b1};

    // Shift source for each slot: the content of the slot just above it
    always_comb begin
        prev_occ = '0;
        for (int i = 0; i < K; i++) begin
            prev_dist[i]  = '0;
            prev_label[i] = '0;
        end
        for (int i = 1; i < K; i++) begin
            prev_occ[i]   = occ_q[i-1];
            prev_dist[i]  = dist_q[i-1];
            prev_label[i] = label_q[i-1];
        end
    end

    assign in_rdy     = (state_q == COLLECT);
    assign out_valid  = (state_q == DRAIN);
    assign do_insert  = in_valid && in_rdy && !le[K-1];
    assign post_count = (do_insert && count_q != CW'(K)) ? count_q + CW'(1) : count_q;
    assign xfer       = out_valid && out_rdy;
    assign last_xfer  = xfer && (rd_ptr_q == count_q - CW'(1));
    assign done_set   = (in_rdy && flush && post_count == '0) || last_xfer;
    assign count      = count_q;
    assign done       = done_q;

    // Output mux driven purely from registered slot state
    always_comb begin
        out_dist  = '0;
        out_label = '0;
        out_last  = 1'b0;
        if (state_q == DRAIN) begin
            out_last = (rd_ptr_q == count_q - CW'(1));
            for (int i = 0; i < K; i++) begin
                if (rd_ptr_q == CW'(i)) begin
                    out_dist  = dist_q[i];
                    out_label = label_q[i];
                end
            end
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= COLLECT;
        else     state_q <= state_d;
    end

    // Next state: empty flush stays in COLLECT and only pulses done
    always_comb begin
        state_d = state_q;
        case (state_q)
            COLLECT: if (flush && post_count != '0) state_d = DRAIN;
            DRAIN:   if (last_xfer)                 state_d = COLLECT;
            default: state_d = COLLECT;
        endcase
    end

    // Slot list, occupancy count, drain pointer and done pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ_q    <= '0;
            count_q  <= '0;
            rd_ptr_q <= '0;
            done_q   <= 1'b0;
            for (int i = 0; i < K; i++) begin
                dist_q[i]  <= '0;
                label_q[i] <= '0;
            end
        end else begin
            done_q <= done_set;
            if (do_insert) begin
                count_q <= post_count;
                for (int i = 0; i < K; i++) begin
                    if (!le_ext[i+1]) begin
                        if (le_ext[i]) begin
                            occ_q[i]   <= 1'b1;
                            dist_q[i]  <= in_key;
                            label_q[i] <= in_label;
                        end else begin
                            occ_q[i]   <= prev_occ[i];
                            dist_q[i]  <= prev_dist[i];
                            label_q[i] <= prev_label[i];
                        end
                    end
                end
            end else if (xfer) begin
                if (last_xfer) begin
                    occ_q    <= '0;
                    count_q  <= '0;
                    rd_ptr_q <= '0;
                    for (int i = 0; i < K; i++) begin
                        dist_q[i]  <= '0;
                        label_q[i] <= '0;
                    end
                end else begin
                    rd_ptr_q <= rd_ptr_q + CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_knn_select.sv
// Scoreboard bench for knn_select: one float-mode and one integer-mode
// instance share stimulus; each has its own expected-output queue.

module tb_knn_select;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, flush, out_rdy;
    logic [31:0] in_dist;
    logic [7:0]  in_label;

    logic        in_rdy_f, out_valid_f, out_last_f, done_f;
    logic [31:0] out_dist_f;
    logic [7:0]  out_label_f;
    logic [2:0]  count_f;

    logic        in_rdy_i, out_valid_i, out_last_i, done_i;
    logic [31:0] out_dist_i;
    logic [7:0]  out_label_i;
    logic [2:0]  count_i;

    int total = 0;
    int bad   = 0;

    logic [40:0] q_f[$];
    logic [40:0] q_i[$];

    always #5 clk = ~clk;

    knn_select #(.VARWIDTH(32), .LABELWIDTH(8), .K(4), .FLOAT(1)) u_dut_f (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_rdy(in_rdy_f),
        .in_dist(in_dist), .in_label(in_label), .flush(flush),
        .out_valid(out_valid_f), .out_rdy(out_rdy), .out_dist(out_dist_f),
        .out_label(out_label_f), .out_last(out_last_f), .count(count_f), .done(done_f)
    );

    knn_select #(.VARWIDTH(32), .LABELWIDTH(8), .K(4), .FLOAT(0)) u_dut_i (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_rdy(in_rdy_i),
        .in_dist(in_dist), .in_label(in_label), .flush(flush),
        .out_valid(out_valid_i), .out_rdy(out_rdy), .out_dist(out_dist_i),
        .out_label(out_label_i), .out_last(out_last_i), .count(count_i), .done(done_i)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pop on every handshake, peek the head while stalled
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid_f) begin
                if (q_f.size() == 0) begin
                    if (out_rdy) chk("f_unexpected_out", {out_last_f, out_label_f, out_dist_f}, 64'h1_ffff_ffff_ffff);
                end else if (out_rdy) begin
                    chk("f_out_entry", {out_last_f, out_label_f, out_dist_f}, q_f.pop_front());
                end else begin
                    chk("f_stall_hold", {out_last_f, out_label_f, out_dist_f}, q_f[0]);
                end
            end
            if (out_valid_i) begin
                if (q_i.size() == 0) begin
                    if (out_rdy) chk("i_unexpected_out", {out_last_i, out_label_i, out_dist_i}, 64'h1_ffff_ffff_ffff);
                end else if (out_rdy) begin
                    chk("i_out_entry", {out_last_i, out_label_i, out_dist_i}, q_i.pop_front());
                end else begin
                    chk("i_stall_hold", {out_last_i, out_label_i, out_dist_i}, q_i[0]);
                end
            end
        end
    end

    task automatic push_both(input logic [31:0] d, input logic [7:0] l, input logic last);
        q_f.push_back({last, l, d});
        q_i.push_back({last, l, d});
    endtask

    task automatic insert(input logic [31:0] d, input logic [7:0] l);
        in_valid = 1'b1;
        in_dist  = d;
        in_label = l;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
    endtask

    task automatic expect_done_after(input int n, input string tag);
        repeat (n) @(posedge clk);
        #1;
        chk({tag, "_done_f"},  done_f,   1);
        chk({tag, "_done_i"},  done_i,   1);
        chk({tag, "_count_f"}, count_f,  0);
        chk({tag, "_in_rdy"},  in_rdy_f, 1);
        @(posedge clk); #1;
        chk({tag, "_done_pulse"}, done_f, 0);
        chk({tag, "_sb_drained"}, q_f.size() + q_i.size(), 0);
    endtask

    initial begin
        logic pat [5];
        pat = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_rdy = 1'b1;
        in_dist = '0; in_label = '0;
        #2;
        chk("rst_in_rdy",    in_rdy_f,    1);
        chk("rst_out_valid", out_valid_f, 0);
        chk("rst_out_dist",  out_dist_f,  0);
        chk("rst_out_label", out_label_f, 0);
        chk("rst_out_last",  out_last_f,  0);
        chk("rst_count",     count_f,     0);
        chk("rst_done",      done_f,      0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Basic: six inserts, the two largest are pushed out
        insert(50, 1); insert(10, 2); insert(30, 3);
        insert(20, 4); insert(40, 5); insert(5, 6);
        chk("basic_count", count_f, 4);
        chk("basic_count_i", count_i, 4);
        push_both(5, 6, 0); push_both(10, 2, 0); push_both(20, 4, 0); push_both(30, 3, 1);
        do_flush();
        chk("basic_first_valid", out_valid_f, 1);
        expect_done_after(4, "basic");

        // Ties keep arrival order
        insert(7, 8'hA); insert(7, 8'hB); insert(3, 8'hC);
        chk("ties_count", count_f, 3);
        push_both(3, 8'hC, 0); push_both(7, 8'hA, 0); push_both(7, 8'hB, 1);
        do_flush();
        expect_done_after(3, "ties");

        // Backpressure
        insert(100, 7); insert(60, 8);
        chk("bp_count", count_f, 2);
        push_both(60, 8, 0); push_both(100, 7, 1);
        do_flush();
        for (int k = 0; k < 5; k++) begin
            out_rdy = pat[k];
            chk("bp_in_rdy_low", in_rdy_f, 0);
            chk("bp_no_done", done_f, 0);
            @(posedge clk); #1;
        end
        out_rdy = 1'b1;
        chk("bp_done", done_f, 1);
        chk("bp_in_rdy", in_rdy_f, 1);
        chk("bp_sb_drained", q_f.size() + q_i.size(), 0);
        @(posedge clk); #1;

        // Empty flush
        do_flush();
        chk("empty_done", done_f, 1);
        chk("empty_no_valid", out_valid_f, 0);
        @(posedge clk); #1;
        chk("empty_done_pulse", done_f, 0);
        chk("empty_no_valid2", out_valid_f, 0);

        // Flush with a pair in the same cycle
        in_valid = 1'b1; in_dist = 9; in_label = 8'h9; flush = 1'b1;
        push_both(9, 8'h9, 1);
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        expect_done_after(1, "flush_in");

        // Float ordering, -0.0 collapses to 0; integer instance sorts raw bits
        insert(32'h40400000, 1); insert(32'h3F800000, 2);
        insert(32'h80000000, 3); insert(32'h41200000, 4);
        q_f.push_back({1'b0, 8'd3, 32'h00000000});
        q_f.push_back({1'b0, 8'd2, 32'h3F800000});
        q_f.push_back({1'b0, 8'd1, 32'h40400000});
        q_f.push_back({1'b1, 8'd4, 32'h41200000});
        q_i.push_back({1'b0, 8'd2, 32'h3F800000});
        q_i.push_back({1'b0, 8'd1, 32'h40400000});
        q_i.push_back({1'b0, 8'd4, 32'h41200000});
        q_i.push_back({1'b1, 8'd3, 32'h80000000});
        do_flush();
        expect_done_after(4, "float");

        // Async reset during a drain
        insert(15, 1); insert(25, 2);
        push_both(15, 1, 0);
        do_flush();
        @(posedge clk); #1;
        chk("rstmid_pre_valid", out_valid_f, 1);
        #1 rst = 1'b1;
        #1;
        chk("rstmid_out_valid", out_valid_f, 0);
        chk("rstmid_count",     count_f,     0);
        chk("rstmid_in_rdy",    in_rdy_f,    1);
        chk("rstmid_done",      done_f,      0);
        @(posedge clk); #1;
        chk("rstmid_done_hold", done_f, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rstmid_no_done", done_f, 0);
        insert(4, 4);
        chk("rstmid_count_after", count_f, 1);
        push_both(4, 4, 1);
        do_flush();
        expect_done_after(1, "rstmid");

        repeat (2) @(posedge clk);
        #1;
        chk("final_sb_f", q_f.size(), 0);
        chk("final_sb_i", q_i.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/knn_select.md
# knn_select

Downstream stage of the Euclidean distance calculator. Accepts a stream of (distance, label) pairs, one per handshake, and keeps the K smallest distances in a sorted register list using a single-cycle parallel compare-and-shift insertion. On a flush request it streams the retained entries out in ascending distance order, then clears itself for the next query vector. The output feeds the classification vote logic.

## Interface
- VARWIDTH, 32, width of a distance word (IEEE-754 single when FLOAT=1, unsigned integer otherwise)
- LABELWIDTH, 8, width of the class label carried with each distance
- K, 4, number of nearest entries retained (1..16)
- FLOAT, 1, compare mode: 1 = non-negative IEEE-754, 0 = unsigned integer

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  input pair present
- in_rdy  out  1  block accepts input this cycle
- in_dist  in  VARWIDTH  distance value
- in_label  in  LABELWIDTH  label of the training vector
- flush  in  1  end of query: begin draining (sampled when in_rdy=1)
- out_valid  out  1  output entry present
- out_rdy  in  1  consumer accepts output entry
- out_dist  out  VARWIDTH  retained distance
- out_label  out  LABELWIDTH  retained label
- out_last  out  1  marks final entry of a drain
- count  out  clog2(K+1)  number of occupied slots
- done  out  1  one-cycle pulse when a drain completes

## Operation
- Storage: K slots, each {occ, dist, label}; slot 0 holds the smallest distance. Occupied slots are contiguous from slot 0.
- Compare: FLOAT=1 compares bit patterns as unsigned with sign bit ignored (inputs are non-negative; -0.0 treated as +0.0); FLOAT=0 plain unsigned compare. Unoccupied slots compare as larger than any value.
- Insertion (handshake in_valid & in_rdy): position p = number of occupied slots with dist <= in_dist. If p < K: slots p..K-2 shift to p+1..K-1, slot K-1 content discarded, new pair written to slot p, count saturates at K. If p = K: input dropped, state unchanged.
- Ties: earlier-accepted entry stays ahead; equal distance inserts after existing equal entries.
- States: COLLECT and DRAIN.
  - COLLECT: in_rdy=1, out_valid=0. flush=1 moves to DRAIN; a pair accepted in the same cycle as flush is inserted first and is included in the drain.
  - flush with count=0 after that insertion: stay in COLLECT, pulse done next cycle, no output entries.
  - DRAIN: in_rdy=0, flush ignored. Read pointer r starts at 0; out_valid=1, out_dist/out_label = slot r, out_last = (r == count-1). On out_valid & out_rdy: r increments; on the last entry, all slots cleared, count=0, done pulses next cycle, return to COLLECT.
  - out_rdy low holds the entry stable; no data change while out_valid=1 and out_rdy=0.
- rst mid-operation: immediate clear of all slots and return to COLLECT; any partial drain is abandoned without done.

## Timing
- Reset values: in_rdy=1, out_valid=0, out_dist=0, out_label=0, out_last=0, count=0, done=0; state COLLECT; all occ=0.
- Insertion latency 1 cycle: count and slot contents update on the edge of acceptance; back-to-back insertion every cycle sustained.
- Flush to first out_valid: 1 cycle. Drain of n entries with out_rdy held high: n cycles, done asserted the cycle after the last handshake, in_rdy=1 in that same cycle.
- Outputs are registered; no combinational path from in_valid/in_dist to out_* or from out_rdy to in_rdy.
- done is a single-cycle pulse, never asserted during reset.

## Test plan
- K=4, FLOAT=0: insert dists 50,10,30,20,40,5 (labels 1..6), flush, out_rdy=1 -> outputs (5,6),(10,2),(20,4),(30,3); out_last on 4th; done 1 cycle later; count=0.
- Ties: insert 7(label A), 7(B), 3(C), flush -> (3,C),(7,A),(7,B); count=3 before flush.
- Backpressure: 2 entries, flush, out_rdy toggles 0,1,0,0,1 -> each entry held stable while stalled; exactly 2 transfers; in_rdy stays 0 until done.
- Empty flush and flush-with-input: flush with count=0 -> no out_valid, done next cycle; flush with in_valid dist=9 same cycle -> single output (9), out_last=1.
- FLOAT=1: insert 0x40400000(3.0), 0x3F800000(1.0), 0x80000000(-0.0), 0x41200000(10.0) -> drain order -0.0 (as 0), 1.0, 3.0, 10.0.
- Async reset asserted during DRAIN after first transfer -> out_valid=0, count=0, in_rdy=1 immediately, no done pulse; subsequent insert of 4 then flush yields (4) only.
